// File: rtl/stage_ex_muldiv.sv
// RV-M multiply/divide unit for the EX stage: fixed-latency multiplier, radix-2 restoring divider.
// Define MULDIV_DIV_EN to build the divider; without it DIV-class ops complete as illegal.
module stage_ex_muldiv #(
    parameter int XLEN    = 32,
    parameter int MUL_LAT = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    input  logic [3:0]      ex_fb_sel,
    input  logic [2:0]      ex_func3_code,
    input  logic [XLEN-1:0] op_A,
    input  logic [XLEN-1:0] op_B,
    input  logic            ex_flush,
    output logic            md_busy,
    output logic            md_done,
    output logic [XLEN-1:0] md_result,
    output logic            md_illegal
);

    localparam int            CW       = $clog2(XLEN) + 1;
    localparam logic [CW-1:0] MUL_LAST = CW'(MUL_LAT - 1);
    localparam logic [3:0]    FB_MUL   = 4'd3;
    localparam logic [3:0]    FB_DIV   = 4'd4;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            accept;
    logic            load_res;
    logic [XLEN-1:0] res_nxt;
    logic            ill_nxt;
    logic            lat_op;
    logic [XLEN-1:0] a_p0, b_p0;
    logic [2:0]      func_p0;
    logic [XLEN-1:0] res_pend, res_hold;
    logic            ill_pend;

    // Full 2*XLEN product; extending both operands to 2*XLEN makes the truncated product exact.
    function automatic logic [XLEN-1:0] mul_result(input logic [XLEN-1:0] a,
                                                   input logic [XLEN-1:0] b,
                                                   input logic [2:0]      f);
        logic signed [2*XLEN-1:0] ea, eb, prod;
        logic                     a_sgn, b_sgn;
        a_sgn = (f == 3'b001) || (f == 3'b010);
        b_sgn = (f == 3'b001);
        ea    = a_sgn ? {{XLEN{a[XLEN-1]}}, a} : {{XLEN{1'b0}}, a};
        eb    = b_sgn ? {{XLEN{b[XLEN-1]}}, b} : {{XLEN{1'b0}}, b};
        prod  = ea * eb;
        return (f == 3'b000) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    endfunction

    assign accept = (state_q == IDLE) && ex_valid && !ex_flush &&
                    ((ex_fb_sel == FB_MUL) || (ex_fb_sel == FB_DIV));

`ifdef MULDIV_DIV_EN
    logic [XLEN-1:0] quo_q, rem_q, dvs_q;
    logic            neg_q_q, neg_r_q, is_rem_q;
    logic            div_init;
    logic            div_sgn;
    logic            div_by_zero, div_ovf;
    logic [XLEN:0]   r_sh;
    logic            borrow;
    logic [XLEN-1:0] rem_nxt, quo_nxt;

    function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v, input logic sgn);
        return (sgn && v[XLEN-1]) ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [XLEN-1:0] sign_fix(input logic [XLEN-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    assign div_sgn     = ~ex_func3_code[0];
    assign div_by_zero = (op_B == '0);
    assign div_ovf     = div_sgn && (op_A == {1'b1, {(XLEN-1){1'b0}}}) && (op_B == '1);

    // One restoring step: dividend bits enter the partial remainder MSB first, quotient bits enter at the LSB.
    always_comb begin
        r_sh    = {rem_q, quo_q[XLEN-1]};
        borrow  = (r_sh < {1'b0, dvs_q});
        rem_nxt = borrow ? r_sh[XLEN-1:0] : (r_sh[XLEN-1:0] - dvs_q);
        quo_nxt = {quo_q[XLEN-2:0], ~borrow};
    end

    always_ff @(posedge clk) begin
        if (div_init) begin
            quo_q    <= abs_val(op_A, div_sgn);
            rem_q    <= '0;
            dvs_q    <= abs_val(op_B, div_sgn);
            neg_q_q  <= div_sgn & (op_A[XLEN-1] ^ op_B[XLEN-1]);
            neg_r_q  <= div_sgn & op_A[XLEN-1];
            is_rem_q <= ex_func3_code[1];
        end else if (state_q == DIV) begin
            quo_q <= quo_nxt;
            rem_q <= rem_nxt;
        end
    end
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        load_res = 1'b0;
        res_nxt  = '0;
        ill_nxt  = 1'b0;
        lat_op   = 1'b0;
`ifdef MULDIV_DIV_EN
        div_init = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (ex_fb_sel == FB_MUL) begin
                        lat_op = 1'b1;
                        if (MUL_LAT == 1) begin
                            state_d  = DONE;
                            load_res = 1'b1;
                            res_nxt  = mul_result(op_A, op_B, ex_func3_code);
                        end else begin
                            state_d = MUL;
                            cnt_d   = CW'(1);
                        end
                    end else begin
`ifdef MULDIV_DIV_EN
                        if (div_by_zero) begin
                            state_d  = DONE;
                            load_res = 1'b1;
                            res_nxt  = ex_func3_code[1] ? op_A : '1;
                        end else if (div_ovf) begin
                            state_d  = DONE;
                            load_res = 1'b1;
                            res_nxt  = ex_func3_code[1] ? '0 : op_A;
                        end else begin
                            state_d  = DIV;
                            cnt_d    = '0;
                            div_init = 1'b1;
                        end
`else
                        state_d  = DONE;
                        load_res = 1'b1;
                        ill_nxt  = 1'b1;
`endif
                    end
                end
            end
            MUL: begin
                if (ex_flush) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == MUL_LAST) begin
                    state_d  = DONE;
                    cnt_d    = '0;
                    load_res = 1'b1;
                    res_nxt  = mul_result(a_p0, b_p0, func_p0);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DIV: begin
`ifdef MULDIV_DIV_EN
                if (ex_flush) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(XLEN - 1)) begin
                    // Last iteration folds the sign fix into the result load.
                    state_d  = DONE;
                    cnt_d    = '0;
                    load_res = 1'b1;
                    res_nxt  = is_rem_q ? sign_fix(rem_nxt, neg_r_q) : sign_fix(quo_nxt, neg_q_q);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`else
                state_d = IDLE;
                cnt_d   = '0;
`endif
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            res_pend <= '0;
            ill_pend <= 1'b0;
            res_hold <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (load_res) begin
                res_pend <= res_nxt;
                ill_pend <= ill_nxt;
            end
            // A flushed DONE never publishes its result, so the held value survives.
            if ((state_q == DONE) && !ex_flush) begin
                res_hold <= res_pend;
            end
        end
    end

    // Operand latch on accept
    always_ff @(posedge clk) begin
        if (lat_op) begin
            a_p0    <= op_A;
            b_p0    <= op_B;
            func_p0 <= ex_func3_code;
        end
    end

    assign md_done    = (state_q == DONE) && !ex_flush;
    assign md_busy    = accept || (state_q == MUL) || (state_q == DIV);
    assign md_result  = md_done ? res_pend : res_hold;
    assign md_illegal = md_done && ill_pend;

endmodule

// File: tb/tb_stage_ex_muldiv.sv
// Randomized self-checking bench for stage_ex_muldiv against an arithmetic reference model.
// Follows the MULDIV_DIV_EN define of the build.
module tb_stage_ex_muldiv;

    localparam int XLEN    = 32;
    localparam int MUL_LAT = 2;
`ifdef MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            ex_valid;
    logic [3:0]      ex_fb_sel;
    logic [2:0]      ex_func3_code;
    logic [XLEN-1:0] op_A, op_B;
    logic            ex_flush;
    logic            md_busy, md_done, md_illegal;
    logic [XLEN-1:0] md_result;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] last_res = '0;

    always #5 clk = ~clk;

    stage_ex_muldiv #(.XLEN(XLEN), .MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_fb_sel(ex_fb_sel),
        .ex_func3_code(ex_func3_code), .op_A(op_A), .op_B(op_B), .ex_flush(ex_flush),
        .md_busy(md_busy), .md_done(md_done), .md_result(md_result), .md_illegal(md_illegal)
    );

    function automatic logic [31:0] model_mul(input logic [31:0] a, input logic [31:0] b,
                                              input logic [2:0] f);
        longint ea, eb, p;
        ea = (f == 3'd1 || f == 3'd2) ? longint'($signed(a)) : longint'({32'b0, a});
        eb = (f == 3'd1) ? longint'($signed(b)) : longint'({32'b0, b});
        p  = ea * eb;
        return (f == 3'd0) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [31:0] model_div(input logic [31:0] a, input logic [31:0] b,
                                              input logic [2:0] f);
        int sa, sb;
        if (b == 32'd0) return f[1] ? a : 32'hFFFF_FFFF;
        if (!f[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f[1] ? 32'd0 : a;
            sa = $signed(a);
            sb = $signed(b);
            return f[1] ? 32'(sa % sb) : 32'(sa / sb);
        end
        return f[1] ? (a % b) : (a / b);
    endfunction

    function automatic logic [31:0] exp_res(input logic [3:0] fb, input logic [2:0] f,
                                            input logic [31:0] a, input logic [31:0] b);
        if (fb == 4'd3) return model_mul(a, b, f);
        if (!DIV_EN) return 32'd0;
        return model_div(a, b, f);
    endfunction

    function automatic int exp_lat(input logic [3:0] fb, input logic [2:0] f,
                                   input logic [31:0] a, input logic [31:0] b);
        if (fb == 4'd3) return MUL_LAT;
        if (!DIV_EN) return 1;
        if (b == 32'd0) return 1;
        if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return XLEN + 1;
    endfunction

    task automatic run_op(input logic [3:0] fb, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] xres, input int xlat,
                          input string name, input bit skip_wait);
        int   k;
        bit   done, busy_bad;
        logic xill;
        xill = (fb == 4'd4) && !DIV_EN;
        if (!skip_wait) @(negedge clk);
        ex_valid = 1'b1; ex_fb_sel = fb; ex_func3_code = f; op_A = a; op_B = b;
        #1;
        n_checks++;
        if (md_busy !== 1'b1) $display("FAIL %s accept_busy: got %b want 1", name, md_busy);
        else n_pass++;
        k = 0; done = 1'b0; busy_bad = 1'b0;
        while (!done && k < 100) begin
            @(negedge clk);
            k++;
            if (md_done === 1'b1) done = 1'b1;
            else if (md_busy !== 1'b1) busy_bad = 1'b1;
        end
        n_checks++;
        if (!done) $display("FAIL %s done_timeout: no md_done in %0d cycles", name, k);
        else n_pass++;
        n_checks++;
        if (k != xlat) $display("FAIL %s latency: got %0d want %0d", name, k, xlat);
        else n_pass++;
        n_checks++;
        if (md_result !== xres) $display("FAIL %s result: got %h want %h", name, md_result, xres);
        else n_pass++;
        n_checks++;
        if (md_illegal !== xill) $display("FAIL %s illegal: got %b want %b", name, md_illegal, xill);
        else n_pass++;
        n_checks++;
        if (md_busy !== 1'b0) $display("FAIL %s busy_in_done: got %b want 0", name, md_busy);
        else n_pass++;
        n_checks++;
        if (busy_bad) $display("FAIL %s busy_while_waiting: got 0 want 1", name);
        else n_pass++;
        ex_valid = 1'b0;
        last_res = xres;
    endtask

    task automatic test_reset;
        rst = 1'b1; ex_valid = 1'b0; ex_fb_sel = '0; ex_func3_code = '0;
        op_A = '0; op_B = '0; ex_flush = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (md_done !== 1'b0) $display("FAIL reset md_done: got %b want 0", md_done); else n_pass++;
        n_checks++;
        if (md_busy !== 1'b0) $display("FAIL reset md_busy: got %b want 0", md_busy); else n_pass++;
        n_checks++;
        if (md_illegal !== 1'b0) $display("FAIL reset md_illegal: got %b want 0", md_illegal); else n_pass++;
        n_checks++;
        if (md_result !== 32'd0) $display("FAIL reset md_result: got %h want 0", md_result); else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_mul_directed;
        run_op(4'd3, 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT, "mul_7x-3", 1'b0);
        run_op(4'd3, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT, "mulhu_max", 1'b0);
        run_op(4'd3, 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, MUL_LAT, "mulh_m1", 1'b0);
        run_op(4'd3, 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT, "mulhsu_m1", 1'b0);
    endtask

    task automatic test_div_directed;
`ifdef MULDIV_DIV_EN
        run_op(4'd4, 3'b100, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, XLEN + 1, "div_-20_3", 1'b0);
        run_op(4'd4, 3'b110, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, XLEN + 1, "rem_-20_3", 1'b0);
        run_op(4'd4, 3'b101, 32'h1234, 32'd0, 32'hFFFF_FFFF, 1, "divu_by0", 1'b0);
        run_op(4'd4, 3'b111, 32'h1234, 32'd0, 32'h0000_1234, 1, "remu_by0", 1'b0);
        run_op(4'd4, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf", 1'b0);
        run_op(4'd4, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1, "rem_ovf", 1'b0);
`else
        run_op(4'd4, 3'b100, 32'hFFFF_FFEC, 32'd3, 32'd0, 1, "div_illegal", 1'b0);
        run_op(4'd4, 3'b111, 32'h1234, 32'd0, 32'd0, 1, "remu_illegal", 1'b0);
`endif
    endtask

    task automatic test_random_mul;
        logic [31:0] a, b;
        logic [2:0]  f;
        for (int i = 0; i < 16; i++) begin
            a = $urandom; b = $urandom; f = 3'($urandom_range(0, 3));
            if (i % 5 == 0) a = 32'h8000_0000;
            run_op(4'd3, f, a, b, exp_res(4'd3, f, a, b), exp_lat(4'd3, f, a, b), "rand_mul", 1'b0);
        end
    endtask

    task automatic test_random_div;
        logic [31:0] a, b;
        logic [2:0]  f;
        for (int i = 0; i < 12; i++) begin
            a = $urandom; b = $urandom; f = 3'($urandom_range(4, 7));
            if (i % 3 == 1) b = 32'($urandom_range(1, 50));
            if (i % 4 == 2) b = 32'd0;
            if (i == 7) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            run_op(4'd4, f, a, b, exp_res(4'd4, f, a, b), exp_lat(4'd4, f, a, b), "rand_div", 1'b0);
        end
    endtask

    task automatic test_hold;
        ex_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (md_done !== 1'b0) $display("FAIL hold md_done: got %b want 0", md_done); else n_pass++;
            n_checks++;
            if (md_result !== last_res) $display("FAIL hold md_result: got %h want %h", md_result, last_res);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back;
        run_op(4'd3, 3'b000, 32'd11, 32'd13, 32'd143, MUL_LAT, "b2b_0", 1'b0);
        run_op(4'd3, 3'b011, 32'h1_0000, 32'h1_0000, 32'd1, MUL_LAT, "b2b_1", 1'b0);
        @(negedge clk);
        n_checks++;
        if (md_done !== 1'b0) $display("FAIL b2b done_one_cycle: got %b want 0", md_done); else n_pass++;
        n_checks++;
        if (md_busy !== 1'b0) $display("FAIL b2b no_reissue: got %b want 0", md_busy); else n_pass++;
    endtask

    task automatic test_flush;
        logic [3:0]  fb;
        logic [2:0]  f;
        logic [31:0] a, b;
        int          fl;
        bit          early;
`ifdef MULDIV_DIV_EN
        fb = 4'd4; f = 3'b100; a = 32'hFFFF_FFEC; b = 32'd3; fl = 5;
`else
        fb = 4'd3; f = 3'b000; a = 32'd5; b = 32'd6; fl = 1;
`endif
        @(negedge clk);
        ex_valid = 1'b1; ex_fb_sel = fb; ex_func3_code = f; op_A = a; op_B = b;
        early = 1'b0;
        for (int i = 1; i <= fl; i++) begin
            @(negedge clk);
            if (md_done !== 1'b0) early = 1'b1;
        end
        ex_flush = 1'b1;
        #1;
        n_checks++;
        if (early || md_done !== 1'b0) $display("FAIL flush done_before: got %b want 0", md_done); else n_pass++;
        @(negedge clk);
        ex_flush = 1'b0; ex_valid = 1'b0;
        #1;
        n_checks++;
        if (md_busy !== 1'b0) $display("FAIL flush busy_after: got %b want 0", md_busy); else n_pass++;
        n_checks++;
        if (md_done !== 1'b0) $display("FAIL flush done_after: got %b want 0", md_done); else n_pass++;
        n_checks++;
        if (md_result !== last_res) $display("FAIL flush result_kept: got %h want %h", md_result, last_res);
        else n_pass++;
        run_op(4'd3, 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT, "mul_after_flush", 1'b1);
        // Flush landing on the DONE cycle of a one-cycle op
        @(negedge clk);
        ex_valid = 1'b1; ex_fb_sel = 4'd4; ex_func3_code = 3'b101; op_A = 32'h1234; op_B = 32'd0;
        @(negedge clk);
        ex_flush = 1'b1;
        #1;
        n_checks++;
        if (md_done !== 1'b0) $display("FAIL flush_done md_done: got %b want 0", md_done); else n_pass++;
        n_checks++;
        if (md_illegal !== 1'b0) $display("FAIL flush_done md_illegal: got %b want 0", md_illegal); else n_pass++;
        n_checks++;
        if (md_result !== last_res) $display("FAIL flush_done result: got %h want %h", md_result, last_res);
        else n_pass++;
        @(negedge clk);
        ex_flush = 1'b0; ex_valid = 1'b0;
        #1;
        n_checks++;
        if (md_result !== last_res) $display("FAIL flush_done result_after: got %h want %h", md_result, last_res);
        else n_pass++;
        n_checks++;
        if (md_busy !== 1'b0 || md_done !== 1'b0)
            $display("FAIL flush_done idle_after: got busy=%b done=%b want 0 0", md_busy, md_done);
        else n_pass++;
    endtask

    task automatic test_flush_accept;
        @(negedge clk);
        ex_valid = 1'b1; ex_fb_sel = 4'd3; ex_func3_code = 3'b000; op_A = 32'd3; op_B = 32'd4; ex_flush = 1'b1;
        #1;
        n_checks++;
        if (md_busy !== 1'b0) $display("FAIL flush_accept busy: got %b want 0", md_busy); else n_pass++;
        @(negedge clk);
        ex_flush = 1'b0; ex_valid = 1'b0;
        #1;
        n_checks++;
        if (md_busy !== 1'b0 || md_done !== 1'b0)
            $display("FAIL flush_accept no_start: got busy=%b done=%b want 0 0", md_busy, md_done);
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        int n;
`ifdef MULDIV_DIV_EN
        n = 4;
        @(negedge clk);
        ex_valid = 1'b1; ex_fb_sel = 4'd4; ex_func3_code = 3'b101; op_A = 32'd1000; op_B = 32'd7;
`else
        n = 1;
        @(negedge clk);
        ex_valid = 1'b1; ex_fb_sel = 4'd3; ex_func3_code = 3'b000; op_A = 32'd1000; op_B = 32'd7;
`endif
        repeat (n) @(negedge clk);
        rst = 1'b1; ex_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (md_done !== 1'b0 || md_busy !== 1'b0 || md_illegal !== 1'b0 || md_result !== 32'd0)
            $display("FAIL reset_mid outputs: got done=%b busy=%b ill=%b res=%h want all 0",
                     md_done, md_busy, md_illegal, md_result);
        else n_pass++;
        last_res = 32'd0;
        repeat (XLEN + 2) @(negedge clk);
        n_checks++;
        if (md_done !== 1'b0 || md_result !== 32'd0)
            $display("FAIL reset_mid no_late_done: got done=%b res=%h want 0 0", md_done, md_result);
        else n_pass++;
        run_op(4'd3, 3'b000, 32'd9, 32'd9, 32'd81, MUL_LAT, "mul_after_reset", 1'b0);
    endtask

    initial begin
        test_reset();
        test_mul_directed();
        test_div_directed();
        test_random_mul();
        test_random_div();
        test_hold();
        test_back_to_back();
        test_flush();
        test_flush_accept();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/stage_ex_muldiv.md
STAGE_EX_MULDIV -- requirements
Module: stage_ex_muldiv

Interface
REQ-001 Parameter XLEN, default 32: operand and result width; legal values 32 and 64.
REQ-002 Parameter MUL_LAT, default 2: multiply latency in cycles; legal range 1 to 4.
REQ-003 Port clk  in  1: sole clock; all state updates on the rising edge.
REQ-004 Port rst  in  1: reset, synchronous, active-high.
REQ-005 Port ex_valid  in  1: a valid instruction occupies EX this cycle.
REQ-006 Port ex_fb_sel  in  4: functional-block select; 3 = MUL, 4 = DIV, all other values ignored.
REQ-007 Port ex_func3_code  in  3: RV-M func3; 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-008 Port op_A  in  XLEN: forwarded rs1 value.
REQ-009 Port op_B  in  XLEN: forwarded rs2 value.
REQ-010 Port ex_flush  in  1: kill the in-flight operation.
REQ-011 Port md_busy  out  1: pipeline stall request.
REQ-012 Port md_done  out  1: one-cycle completion pulse.
REQ-013 Port md_result  out  XLEN: result, valid while md_done is high.
REQ-014 Port md_illegal  out  1: unsupported-operation flag, valid with md_done.

Function
REQ-015 The FSM SHALL have four states: IDLE, MUL, DIV and DONE.
REQ-016 Accept condition SHALL be: IDLE and ex_valid and ex_fb_sel in {3,4} and not ex_flush; operands and func3 are latched on the accept edge.
REQ-017 md_busy SHALL equal the accept condition OR state in {MUL, DIV}, and SHALL be low in DONE.
REQ-018 Multiply: for an accept in cycle T, md_done SHALL be high in cycle T+MUL_LAT (DONE state), computed from the full 2*XLEN product.
REQ-019 MUL SHALL return the low XLEN bits; MULH/MULHSU/MULHU SHALL return the high XLEN bits with signed*signed, signed*unsigned and unsigned*unsigned operands respectively.
REQ-020 Divide: restoring radix-2 with XLEN iterations, operating on magnitudes with a final sign-fix cycle; for an accept in cycle T, md_done SHALL be high in cycle T+XLEN+1.
REQ-021 Divide by zero SHALL give quotient all-ones and remainder = op_A, with md_done in T+1.
REQ-022 Signed overflow (op_A = most-negative, op_B = -1) for DIV/REM SHALL give quotient = op_A and remainder 0, with md_done in T+1.
REQ-023 Remainder sign SHALL follow the dividend and quotient sign SHALL be the XOR of the operand signs (signed ops only).
REQ-024 DONE SHALL last exactly one cycle and return to IDLE; no accept is possible in DONE, so the stalled instruction is not re-issued.
REQ-025 md_result SHALL be registered and SHALL hold its last value until the next md_done.
REQ-026 ex_flush in any state SHALL force IDLE on the next edge, suppress md_done and leave md_result unchanged; ex_flush in DONE suppresses that cycle's md_done.
REQ-027 ex_flush together with a would-be accept SHALL prevent the accept.

Reset
REQ-028 rst SHALL force state IDLE and clear the iteration counter, md_done, md_busy, md_illegal and md_result to 0 on the next edge, overriding any operation in flight.
REQ-029 rst SHALL take priority over ex_flush and over accept.

Configuration
REQ-030 Macro MULDIV_DIV_EN: when defined, the divider and the DIV state SHALL be compiled in as specified above.
REQ-031 Without MULDIV_DIV_EN, DIV ops SHALL skip the divider and go to DONE at T+1 with md_result 0 and md_illegal 1; MUL ops SHALL be unaffected.

Verification
REQ-032 MUL: op_A=7, op_B=-3 (0xFFFFFFFD), MUL_LAT=2, accept at T -> md_result 0xFFFFFFEB, md_done at T+2, md_busy high at T and T+1.
REQ-033 MULHU: op_A=op_B=0xFFFFFFFF -> md_result 0xFFFFFFFE; MULH with the same operands -> 0x00000000.
REQ-034 DIV: op_A=-20, op_B=3 (XLEN=32) -> md_result 0xFFFFFFFA (-6), md_done at T+33; REM with the same operands -> 0xFFFFFFFE (-2).
REQ-035 DIVU with op_B=0, op_A=0x1234 -> md_result 0xFFFFFFFF at T+1; REMU -> 0x1234; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 at T+1.
REQ-036 Start DIV, assert ex_flush at T+5 -> IDLE at T+6, no md_done, md_result unchanged; a new MUL accepted at T+6 completes at T+8.
REQ-037 Assert rst mid-DIV -> all outputs 0 on the next edge; build without MULDIV_DIV_EN, issue DIV -> md_illegal=1, md_result=0 at T+1.
